// File: rtl/pwm_pattern_gen_mc.sv
// Multi-channel segment-pattern PWM: one shared prescaler and period counter,
// per-channel run FSMs, and a shadow configuration set swapped at period boundaries.
module pwm_pattern_gen_mc #(
   parameter int NCH  = 4,
   parameter int NSEG = 4,
   parameter int CW   = 16,
   parameter int IW   = 8
) (
   input  logic                   clksys,
   input  logic                   rst,
   input  logic [NCH-1:0]         enable,
   input  logic [NCH-1:0]         oneshot,
   input  logic [7:0]             prescale,
   input  logic [CW-1:0]          period,
   input  logic [NCH*NSEG*2-1:0]  pattern,
   input  logic [NCH*NSEG*IW-1:0] interval,
   input  logic                   cfg_load,
   output logic                   cfg_ack,
   output logic [NCH-1:0]         pwm_out,
   output logic [NCH-1:0]         pwm_oe,
   output logic [NCH-1:0]         busy,
   output logic [NCH-1:0]         period_done
);
   localparam int TW = IW + $clog2(NSEG);

   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, RUN = 2'd2} state_t;

   logic [7:0]             sh_prescale;
   logic [7:0]             pre_cnt;
   logic [CW-1:0]          sh_period;
   logic [CW-1:0]          cnt;
   logic [NCH*NSEG*2-1:0]  sh_pattern;
   logic [NCH*NSEG*IW-1:0] sh_interval;
   logic                   pending_reg;
   logic                   tick;
   logic                   boundary;
   logic                   copy;
   logic [NCH-1:0]         run_vec;

   assign tick     = (pre_cnt == sh_prescale);
   assign boundary = tick && (cnt == sh_period);
   // Swap only where no running channel can see a half-old, half-new pattern.
   assign copy     = (boundary && (pending_reg || cfg_load)) || (pending_reg && !(|run_vec));

   always_ff @(posedge clksys or posedge rst) begin
      if (rst) begin
         sh_prescale <= '0;
         sh_period   <= '0;
         sh_pattern  <= '0;
         sh_interval <= '0;
         pending_reg <= 1'b0;
         cfg_ack     <= 1'b0;
         pre_cnt     <= '0;
         cnt         <= '0;
      end else begin
         cfg_ack <= copy;
         if (copy) begin
            sh_prescale <= prescale;
            sh_period   <= period;
            sh_pattern  <= pattern;
            sh_interval <= interval;
            pending_reg <= 1'b0;
         end else if (cfg_load) begin
            pending_reg <= 1'b1;
         end
         if (copy && !(|busy)) begin
            pre_cnt <= '0;
            cnt     <= '0;
         end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= (cnt == sh_period) ? '0 : cnt + CW'(1);
         end else begin
            pre_cnt <= pre_cnt + 8'd1;
         end
      end
   end

   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      state_t     state_reg;
      state_t     state_next;
      logic       os_done_reg;
      logic [1:0] code;
      logic       out_reg;
      logic       oe_reg;
      logic       done_reg;

      // Active segment is the first whose cumulative end lies beyond cnt.
      always_comb begin
         logic [TW-1:0] acc;
         logic          found;
         code  = 2'b00;
         acc   = '0;
         found = 1'b0;
         for (int s = 0; s < NSEG; s++) begin
            acc = acc + TW'(sh_interval[(gi*NSEG+s)*IW +: IW]);
            if (!found && ({{TW{1'b0}}, cnt} < {{CW{1'b0}}, acc})) begin
               code  = sh_pattern[(gi*NSEG+s)*2 +: 2];
               found = 1'b1;
            end
         end
      end

      always_comb begin
         state_next = state_reg;
         case (state_reg)
            IDLE:    if (enable[gi] && !os_done_reg) state_next = ARMED;
            ARMED:   if (!enable[gi]) state_next = IDLE;
                     else if (boundary) state_next = RUN;
            RUN:     if (boundary && (oneshot[gi] || !enable[gi])) state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end

      // A finished one-shot stays parked until enable is withdrawn.
      always_ff @(posedge clksys or posedge rst) begin
         if (rst) begin
            state_reg   <= IDLE;
            os_done_reg <= 1'b0;
            out_reg     <= 1'b0;
            oe_reg      <= 1'b0;
            done_reg    <= 1'b0;
         end else begin
            state_reg <= state_next;
            if (!enable[gi]) begin
               os_done_reg <= 1'b0;
            end else if (state_reg == RUN && boundary && oneshot[gi]) begin
               os_done_reg <= 1'b1;
            end
            out_reg  <= (state_reg == RUN) && (code == 2'b10);
            oe_reg   <= (state_reg == RUN) && ((code == 2'b10) || (code == 2'b01));
            done_reg <= boundary && (state_reg == RUN);
         end
      end

      assign busy[gi]        = (state_reg != IDLE);
      assign run_vec[gi]     = (state_reg == RUN);
      assign pwm_out[gi]     = out_reg;
      assign pwm_oe[gi]      = oe_reg;
      assign period_done[gi] = done_reg;
   end
endmodule
